obuft_bank_ctl: RTL and testbench

Parametrised, registered tri-state output bank with bus-turnaround control. Drives a WIDTH-bit shared bus from a valid/ready data stream. Inserts programmable dead cycles whenever bus ownership is acquired or released. Honours a global tristate input. Sits between internal logic and a shared bidirectional pad bank, replacing per-bit unregistered tri-state buffers.

---
 rtl/obuft_bank_pkg.sv | 23 ++
 rtl/obuft_turn_cnt.sv | 39 +++
 rtl/obuft_bank_ctl.sv | 155 +++++++++++++++
 tb/tb_obuft_bank_ctl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/obuft_bank_pkg.sv
// Shared types and constants for the registered tri-state bank controller.
// Holds the FSM state encoding, the turnaround limit and the counter width helper.
// No logic lives here; it is imported by obuft_bank_ctl and obuft_turn_cnt.
package obuft_bank_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    TURN_ON  = 2'd1,
    DRIVE    = 2'd2,
    TURN_OFF = 2'd3
  } state_e;

  // Largest supported number of dead cycles on an ownership change.
  localparam int TURN_MAX = 15;

  // Bits needed to hold 0..turn_cycles, never less than one.
  function automatic int cnt_width(input int turn_cycles);
    int w;
    w = $clog2(turn_cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/obuft_turn_cnt.sv
// Loadable down-counter timing the hi-Z turnaround window; done when it reaches zero.
// Latency: load/decrement take effect at the next rising edge.
// No backpressure; it saturates at zero instead of wrapping.
module obuft_turn_cnt #(
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          dec,
  output logic          done
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: load wins over decrement, and decrement stops at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/obuft_bank_ctl.sv
// Registered tri-state output bank with dead-cycle bus turnaround on acquire/release.
// Latency: accepted word drives O from the accept edge; GTS gates O combinationally.
// Backpressure: D_READY only in DRIVE while EN & !GTS. Macro OBUFT_BANK_PARITY_EN adds O[WIDTH] parity.
module obuft_bank_ctl
  import obuft_bank_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int TURN_CYCLES = 2
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             GTS,
  input  logic             EN,
  input  logic [WIDTH-1:0] D,
  input  logic             D_VALID,
  output logic             D_READY,
`ifdef OBUFT_BANK_PARITY_EN
  output tri   [WIDTH:0]   O,
`else
  output tri   [WIDTH-1:0] O,
`endif
  output logic             OE,
  output logic             BUSY
);

  localparam int CW = cnt_width(TURN_CYCLES);
  // A zero-cycle turnaround skips TURN_ON/TURN_OFF entirely.
  localparam bit HAS_TURN = (TURN_CYCLES != 0);
  localparam logic [CW-1:0] LOAD_VAL = (TURN_CYCLES > 0) ? CW'(TURN_CYCLES - 1) : '0;

  if ((WIDTH < 1) || (WIDTH > 64)) begin : g_bad_width
    $error("obuft_bank_ctl: WIDTH out of range");
  end
  if ((TURN_CYCLES < 0) || (TURN_CYCLES > TURN_MAX)) begin : g_bad_turn
    $error("obuft_bank_ctl: TURN_CYCLES out of range");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             oe_q, oe_d;
  logic             acq;
  logic             accept;
  logic             cnt_load;
  logic             cnt_dec;
  logic             cnt_done;

  // Ownership is wanted only while requested and not globally tristated.
  assign acq     = EN & ~GTS;
  assign D_READY = (state_q == DRIVE) & acq;
  assign accept  = D_VALID & D_READY;

  obuft_turn_cnt #(
    .CW(CW)
  ) u_turn_cnt (
    .clk      (CLK),
    .rst_n    (RST_N),
    .load     (cnt_load),
    .load_val (LOAD_VAL),
    .dec      (cnt_dec),
    .done     (cnt_done)
  );

  // Next-state and counter control; TURN_OFF is never cut short so the bus
  // always sees the full dead window before anyone re-drives it.
  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (state_q)
      IDLE: begin
        if (acq) begin
          if (HAS_TURN) begin
            state_d  = TURN_ON;
            cnt_load = 1'b1;
          end else begin
            state_d = DRIVE;
          end
        end
      end
      TURN_ON: begin
        if (!acq) begin
          state_d = IDLE;
        end else if (cnt_done) begin
          state_d = DRIVE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      DRIVE: begin
        if (!acq) begin
          if (HAS_TURN) begin
            state_d  = TURN_OFF;
            cnt_load = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      TURN_OFF: begin
        if (cnt_done) begin
          state_d  = acq ? TURN_ON : IDLE;
          cnt_load = acq;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Data and output-enable next values; q holds the last word when idle.
  always_comb begin
    q_d  = accept ? D : q_q;
    oe_d = (state_d == DRIVE);
  end

  // State, data and output-enable registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      q_q     <= '0;
      oe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      oe_q    <= oe_d;
    end
  end

`ifdef OBUFT_BANK_PARITY_EN
  logic par_q, par_d;

  // Parity travels with q so the pad word and its check bit change together.
  always_comb begin
    par_d = accept ? ^D : par_q;
  end

  // Parity register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end

  assign O = (oe_q & ~GTS) ? {par_q, q_q} : {(WIDTH + 1){1'bz}};
`else
  assign O = (oe_q & ~GTS) ? q_q : {WIDTH{1'bz}};
`endif

  assign OE   = oe_q;
  assign BUSY = (state_q != IDLE);

endmodule

// File: tb/tb_obuft_bank_ctl.sv
module tb_obuft_bank_ctl;

`ifdef OBUFT_BANK_PARITY_EN
  localparam int OW = 9;
`else
  localparam int OW = 8;
`endif

  typedef struct {
    logic       en;
    logic       gts;
    logic       vld;
    logic [7:0] d;
    logic       x_oe;
    logic       x_rdy;
    logic       x_busy;
    logic       x_drv;
    logic [7:0] x_o;
  } vec_t;

  typedef struct {
    logic [OW-1:0] o;
    logic          oe;
    logic          rdy;
    logic          busy;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       gts, en, d_vld;
  logic [7:0] d;
  logic       d_rdy, oe, busy;
  wire  [OW-1:0] o_bus;

  logic       gts0, en0, d_vld0;
  logic [7:0] d0;
  logic       d_rdy0, oe0, busy0;
  wire  [OW-1:0] o0_bus;

  int n_tests = 0;
  int n_fail  = 0;

  exp_t sb[$];
  vec_t vt[26];
  vec_t vt0[5];

  always #5 clk = ~clk;

  // Undriven pad bits read as 1 through the pull-ups.
  for (genvar i = 0; i < OW; i++) begin : g_pu
    pullup (o_bus[i]);
    pullup (o0_bus[i]);
  end

  obuft_bank_ctl #(.WIDTH(8), .TURN_CYCLES(2)) dut (
    .CLK(clk), .RST_N(rst_n), .GTS(gts), .EN(en), .D(d), .D_VALID(d_vld),
    .D_READY(d_rdy), .O(o_bus), .OE(oe), .BUSY(busy)
  );

  obuft_bank_ctl #(.WIDTH(8), .TURN_CYCLES(0)) dut0 (
    .CLK(clk), .RST_N(rst_n), .GTS(gts0), .EN(en0), .D(d0), .D_VALID(d_vld0),
    .D_READY(d_rdy0), .O(o0_bus), .OE(oe0), .BUSY(busy0)
  );

  function automatic vec_t mk(logic e, logic g, logic v, logic [7:0] dd,
                              logic xoe, logic xrdy, logic xbusy, logic xdrv, logic [7:0] xo);
    vec_t r;
    r.en = e; r.gts = g; r.vld = v; r.d = dd;
    r.x_oe = xoe; r.x_rdy = xrdy; r.x_busy = xbusy; r.x_drv = xdrv; r.x_o = xo;
    return r;
  endfunction

  // Expected pad value: pulled-up when hi-Z, else data (plus even parity).
  function automatic logic [OW-1:0] exp_bus(logic drv, logic [7:0] v);
    if (!drv) return '1;
`ifdef OBUFT_BANK_PARITY_EN
    return {^v, v};
`else
    return v;
`endif
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  // Drive one vector on the selected instance after a rising edge, queue its
  // expectation, then compare at the falling edge.
  task automatic run_vec(input bit sel0, input vec_t v, input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    if (sel0) begin
      en0 = v.en; gts0 = v.gts; d_vld0 = v.vld; d0 = v.d;
    end else begin
      en = v.en; gts = v.gts; d_vld = v.vld; d = v.d;
    end
    sb.push_back('{exp_bus(v.x_drv, v.x_o), v.x_oe, v.x_rdy, v.x_busy});
    @(negedge clk);
    e = sb.pop_front();
    if (sel0) begin
      chk({tag, ".o"}, 64'(o0_bus), 64'(e.o));
      chk({tag, ".oe"}, 64'(oe0), 64'(e.oe));
      chk({tag, ".rdy"}, 64'(d_rdy0), 64'(e.rdy));
      chk({tag, ".busy"}, 64'(busy0), 64'(e.busy));
    end else begin
      chk({tag, ".o"}, 64'(o_bus), 64'(e.o));
      chk({tag, ".oe"}, 64'(oe), 64'(e.oe));
      chk({tag, ".rdy"}, 64'(d_rdy), 64'(e.rdy));
      chk({tag, ".busy"}, 64'(busy), 64'(e.busy));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    //            en gts vld d      oe rdy busy drv o
    vt[0]  = mk(0, 0, 0, 8'h00,  0, 0, 0, 0, 8'h00);
    vt[1]  = mk(0, 0, 1, 8'h55,  0, 0, 0, 0, 8'h00);
    vt[2]  = mk(1, 0, 1, 8'h11,  0, 0, 0, 0, 8'h00);
    vt[3]  = mk(1, 0, 1, 8'h11,  0, 0, 1, 0, 8'h00);
    vt[4]  = mk(1, 0, 1, 8'h11,  0, 0, 1, 0, 8'h00);
    vt[5]  = mk(1, 0, 1, 8'h11,  1, 1, 1, 1, 8'h00);
    vt[6]  = mk(1, 0, 1, 8'h22,  1, 1, 1, 1, 8'h11);
    vt[7]  = mk(1, 0, 0, 8'h99,  1, 1, 1, 1, 8'h22);
    vt[8]  = mk(1, 0, 0, 8'h99,  1, 1, 1, 1, 8'h22);
    vt[9]  = mk(0, 0, 1, 8'h44,  1, 0, 1, 1, 8'h22);
    vt[10] = mk(1, 0, 1, 8'h44,  0, 0, 1, 0, 8'h00);
    vt[11] = mk(1, 0, 1, 8'h44,  0, 0, 1, 0, 8'h00);
    vt[12] = mk(1, 0, 1, 8'h44,  0, 0, 1, 0, 8'h00);
    vt[13] = mk(1, 0, 1, 8'h3C,  0, 0, 1, 0, 8'h00);
    vt[14] = mk(1, 0, 1, 8'h3C,  1, 1, 1, 1, 8'h22);
    vt[15] = mk(1, 0, 0, 8'h3C,  1, 1, 1, 1, 8'h3C);
    vt[16] = mk(1, 1, 1, 8'h77,  1, 0, 1, 0, 8'h00);
    vt[17] = mk(1, 1, 1, 8'h77,  0, 0, 1, 0, 8'h00);
    vt[18] = mk(1, 1, 1, 8'h77,  0, 0, 1, 0, 8'h00);
    vt[19] = mk(1, 1, 1, 8'h77,  0, 0, 0, 0, 8'h00);
    vt[20] = mk(1, 0, 0, 8'h00,  0, 0, 0, 0, 8'h00);
    vt[21] = mk(0, 0, 0, 8'h00,  0, 0, 1, 0, 8'h00);
    vt[22] = mk(0, 0, 0, 8'h00,  0, 0, 0, 0, 8'h00);
    vt[23] = mk(1, 0, 0, 8'h00,  0, 0, 0, 0, 8'h00);
    vt[24] = mk(1, 1, 0, 8'h00,  0, 0, 1, 0, 8'h00);
    vt[25] = mk(0, 0, 0, 8'h00,  0, 0, 0, 0, 8'h00);

    vt0[0] = mk(1, 0, 1, 8'h07,  0, 0, 0, 0, 8'h00);
    vt0[1] = mk(1, 0, 1, 8'h07,  1, 1, 1, 1, 8'h00);
    vt0[2] = mk(1, 0, 1, 8'h03,  1, 1, 1, 1, 8'h07);
    vt0[3] = mk(0, 0, 0, 8'h03,  1, 0, 1, 1, 8'h03);
    vt0[4] = mk(0, 0, 0, 8'h00,  0, 0, 0, 0, 8'h00);

    // Reset with live stimulus: nothing may drive or start.
    rst_n = 1'b0;
    en = 1'b1; gts = 1'b0; d_vld = 1'b1; d = 8'hA5;
    en0 = 1'b1; gts0 = 1'b0; d_vld0 = 1'b1; d0 = 8'hA5;
    repeat (3) @(negedge clk);
    chk("rst.o", 64'(o_bus), 64'(exp_bus(1'b0, 8'h00)));
    chk("rst.oe", 64'(oe), 64'd0);
    chk("rst.rdy", 64'(d_rdy), 64'd0);
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst0.busy", 64'(busy0), 64'd0);
    chk("rst0.o", 64'(o0_bus), 64'(exp_bus(1'b0, 8'h00)));
    en = 1'b0; en0 = 1'b0;
    rst_n = 1'b1;

    for (int i = 0; i < 26; i++) run_vec(1'b0, vt[i], $sformatf("v%0d", i));

    // Reset while driving: pad releases with no clock edge.
    @(posedge clk); #1; en = 1'b1; d_vld = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rdrv.oe", 64'(oe), 64'd1);
    chk("rdrv.o", 64'(o_bus), 64'(exp_bus(1'b1, 8'h3C)));
    #1; rst_n = 1'b0;
    #1;
    chk("rmid.o", 64'(o_bus), 64'(exp_bus(1'b0, 8'h00)));
    chk("rmid.oe", 64'(oe), 64'd0);
    chk("rmid.busy", 64'(busy), 64'd0);
    @(negedge clk); en = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    chk("rpost.busy", 64'(busy), 64'd0);
    chk("rpost.o", 64'(o_bus), 64'(exp_bus(1'b0, 8'h00)));

    for (int i = 0; i < 5; i++) run_vec(1'b1, vt0[i], $sformatf("z%0d", i));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
